// File: rtl/td4_core.sv
// TD4-style 4-bit execution core: fetches from a combinational program memory,
// executes one instruction per FETCH/EXEC pair, with run and single-step control.
module td4_core #(
    parameter logic [3:0] RESET_PC  = 4'h0,
    parameter logic [3:0] OUT_RESET = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode_in,
    input  logic [3:0] immediate_in,
    input  logic [3:0] in_port,
    output logic [3:0] pc,
    output logic [3:0] out_port,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic       carry,
    output logic       busy,
    output logic       retired,
    output logic       self_loop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A  = 4'b0010;
    localparam logic [3:0] OP_MOV_A = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_IN_B  = 4'b0110;
    localparam logic [3:0] OP_MOV_B = 4'b0111;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_OUT_I = 4'b1011;
    localparam logic [3:0] OP_JNC   = 4'b1110;
    localparam logic [3:0] OP_JMP   = 4'b1111;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       carry_q, carry_d;
    logic [7:0] ir_q, ir_d;
    logic       retired_q, retired_d;
    logic       self_q, self_d;
    logic       step_q, step_d;

    logic       step_rise;
    logic [3:0] op;
    logic [3:0] im;
    logic [4:0] sum_a;
    logic [4:0] sum_b;

    assign step_rise = step & ~step_q;
    assign op        = ir_q[7:4];
    assign im        = ir_q[3:0];
    assign sum_a     = {1'b0, a_q} + {1'b0, im};
    assign sum_b     = {1'b0, b_q} + {1'b0, im};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            a_q       <= 4'h0;
            b_q       <= 4'h0;
            out_q     <= OUT_RESET;
            carry_q   <= 1'b0;
            ir_q      <= 8'h00;
            retired_q <= 1'b0;
            self_q    <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_q     <= out_d;
            carry_q   <= carry_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            self_q    <= self_d;
            step_q    <= step_d;
        end
    end

    // Step rises seen outside IDLE or while running are dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run || step_rise) state_d = FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = run ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        out_d     = out_q;
        carry_d   = carry_q;
        ir_d      = ir_q;
        self_d    = self_q;
        step_d    = step;
        retired_d = (state_q == EXEC);
        if (state_q == FETCH) begin
            ir_d = {opcode_in, immediate_in};
        end
        if (state_q == EXEC) begin
            // Only ADD produces a carry; JNC reads carry_q, the pre-EXEC value.
            carry_d = 1'b0;
            pc_d    = pc_q + 4'd1;
            self_d  = 1'b0;
            case (op)
                OP_ADD_A:  {carry_d, a_d} = sum_a;
                OP_ADD_B:  {carry_d, b_d} = sum_b;
                OP_MOV_A:  a_d = im;
                OP_MOV_B:  b_d = im;
                OP_MOV_AB: a_d = b_q;
                OP_MOV_BA: b_d = a_q;
                OP_IN_A:   a_d = in_port;
                OP_IN_B:   b_d = in_port;
                OP_OUT_B:  out_d = b_q;
                OP_OUT_I:  out_d = im;
                OP_JMP: begin
                    pc_d   = im;
                    self_d = (im == pc_q);
                end
                OP_JNC:    if (!carry_q) pc_d = im;
                default:   ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        pc        = pc_q;
        reg_a     = a_q;
        reg_b     = b_q;
        out_port  = out_q;
        carry     = carry_q;
        retired   = retired_q;
        self_loop = self_q;
    end

endmodule

// File: doc/td4_core.md
Name: td4_core

Overview:
- 4-bit TD4-style execution core, sitting directly downstream of the 16-entry program memory.
- Drives the memory address (the PC) and consumes the memory's 4-bit opcode and 4-bit immediate.
- Executes one instruction per FETCH/EXEC pair and holds registers A, B, the carry flag and the output port.
- Run/single-step control lets the board debug programs loaded through the memory write path.

Parameters:
RESET_PC, 4'h0, PC value loaded on reset
OUT_RESET, 4'h0, out_port value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; high = free-running execution
step  input  1  level; each 0->1 transition, sampled while IDLE and run=0, executes exactly one instruction
opcode_in  input  4  opcode from program memory at address pc
immediate_in  input  4  immediate from program memory at address pc
in_port  input  4  external input port (IN A / IN B)
pc  output  4  program counter; drives memory address
out_port  output  4  registered output port
reg_a  output  4  register A (debug)
reg_b  output  4  register B (debug)
carry  output  1  carry flag
busy  output  1  high in FETCH and EXEC
retired  output  1  one-cycle pulse, the cycle after each EXEC
self_loop  output  1  high while the last retired instruction was JMP to its own address

Behaviour:
- Reset (async, immediate, also mid-instruction):
  - pc=RESET_PC, out_port=OUT_RESET
  - reg_a, reg_b, carry, ir, retired, self_loop = 0
  - step edge register = 0; state = IDLE
- Memory read is combinational. The core holds pc stable for all of FETCH and samples {opcode_in, immediate_in} into the 8-bit ir at the FETCH->EXEC edge.
- States:
  - IDLE: go to FETCH if run=1 or step_rise=1; else stay.
  - FETCH: capture ir; go to EXEC.
  - EXEC: apply the instruction and update pc; next state is FETCH if run=1, else IDLE.
- Throughput: 2 clocks per instruction while run=1.
- step_rise = step & ~step_q, with step_q registered every cycle. Rises occurring outside IDLE, or with run=1, are discarded, not queued.
- run falling mid-instruction: the current instruction completes, then the core goes to IDLE.
- Instruction set, with im = immediate, all arithmetic 4-bit wrapping:
  - 0000 ADD A,im: {carry,A} = A+im
  - 0101 ADD B,im: {carry,B} = B+im
  - 0011 MOV A,im
  - 0111 MOV B,im
  - 0001 MOV A,B
  - 0100 MOV B,A
  - 0010 IN A: A = in_port
  - 0110 IN B: B = in_port
  - 1001 OUT B: out_port = B
  - 1011 OUT im: out_port = im
  - 1111 JMP im: pc = im
  - 1110 JNC im: pc = im if carry==0, else pc+1
  - all other opcodes: NOP
- Carry handling:
  - Every non-ADD instruction, including JNC, NOP and undefined opcodes, clears carry in EXEC.
  - JNC tests the carry value from before its own EXEC.
- PC: pc+1 (4'hF wraps to 4'h0) for every instruction except a taken jump.
- in_port is sampled in EXEC.
- retired is asserted in the cycle after EXEC.
- self_loop is set when a JMP target equals the pc of that JMP, and cleared by any other retired instruction. The core keeps running; self_loop is status only.

Test Plan:
- Reset: assert rst mid-EXEC with pc=5, A=7 -> same cycle pc=0, A=0, B=0, carry=0, out_port=0, busy=0.
- Arithmetic/carry: run=1, memory {0:MOV A,3 (0x33), 1:ADD A,14 (0x0E), 2:JNC 0 (0xE0), 3:OUT im 9 (0xB9)}:
  - after instr1: A=1, carry=1
  - JNC not taken: pc=3
  - after instr3: carry=0, out_port=9
  - retired pulses every 2 clocks
- Branch taken / wrap: {0:MOV B,15 (0x7F), 1:ADD B,0 (0x50), 2:JNC 0 (0xE0)}:
  - carry=0 after ADD, jump to 0, loop repeats
  - then force pc via JMP 15 at 0xF: entry 15 NOP -> pc wraps to 0
- I/O: in_port=0xA, {IN B (0x60), MOV A,B (0x10), OUT B (0x90)} -> A=0xA, B=0xA, out_port=0xA; changing in_port afterwards leaves the registers unchanged.
- Single-step:
  - run=0, hold step high 10 cycles -> exactly one instruction, one retired pulse, back to IDLE
  - toggle step during FETCH -> ignored, no second instruction
- Self-loop / run drop:
  - entry 4 = JMP 4 (0xF4) -> self_loop=1, pc stays 4
  - deassert run during FETCH -> EXEC completes, then IDLE, busy=0
